// File: rtl/text_pkg.sv
// Shared text-mode constants: screen geometry, control codes and writer FSM encoding.
// Also consumed by the renderer, so geometry changes stay in one place.
package text_pkg;

  localparam int COLS  = 10;
  localparam int ROWS  = 8;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SCR_RD   = 3'd1;
  localparam logic [2:0] ST_SCR_WR   = 3'd2;
  localparam logic [2:0] ST_CLR_LINE = 3'd3;
  localparam logic [2:0] ST_CLR_ALL  = 3'd4;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Character stream to text-buffer writer: cursor tracking, backspace, form feed
// and a read/write scroll engine over an external dual-port buffer.
module text_console_writer #(
  parameter int COLS  = text_pkg::COLS,
  parameter int ROWS  = text_pkg::ROWS,
  parameter int CELLS = text_pkg::CELLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [6:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] cursor_col,
  output logic [2:0] cursor_row
);

  import text_pkg::*;

  logic [2:0] r_state;
  logic [6:0] r_idx;
  logic [3:0] r_col;
  logic [2:0] r_row;
  logic       r_wr_en;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;

  logic [6:0] w_cur_addr;
  logic       w_col_last;
  logic       w_row_last;

  assign w_cur_addr = 7'(r_row) * 7'(COLS) + 7'(r_col);
  assign w_col_last = (r_col == 4'(COLS - 1));
  assign w_row_last = (r_row == 3'(ROWS - 1));

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = !in_ready;
  // Combinational so the buffer sees the address during SCR_RD and returns data in SCR_WR.
  assign rd_addr    = (r_state == ST_SCR_RD) ? r_idx + 7'(COLS) : 7'd0;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= 7'd0;
      r_col     <= 4'd0;
      r_row     <= 3'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 7'd0;
      r_wr_data <= 8'd0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_printable(in_char)) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_cur_addr;
              r_wr_data <= in_char;
              if (w_col_last) begin
                r_col <= 4'd0;
                if (w_row_last) begin
                  r_state <= ST_SCR_RD;
                  r_idx   <= 7'd0;
                end else begin
                  r_row <= r_row + 3'd1;
                end
              end else begin
                r_col <= r_col + 4'd1;
              end
            end else begin
              case (in_char)
                LF: begin
                  r_col <= 4'd0;
                  if (w_row_last) begin
                    r_state <= ST_SCR_RD;
                    r_idx   <= 7'd0;
                  end else begin
                    r_row <= r_row + 3'd1;
                  end
                end
                CR: r_col <= 4'd0;
                BS: begin
                  if (r_col != 4'd0) begin
                    r_col     <= r_col - 4'd1;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_cur_addr - 7'd1;
                    r_wr_data <= SPACE;
                  end
                end
                FF: begin
                  r_state <= ST_CLR_ALL;
                  r_idx   <= 7'd0;
                  r_col   <= 4'd0;
                  r_row   <= 3'd0;
                end
                default: ;
              endcase
            end
          end
        end
        ST_SCR_RD: r_state <= ST_SCR_WR;
        ST_SCR_WR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_idx;
          r_wr_data <= rd_data;
          if (r_idx == 7'(CELLS - COLS - 1)) begin
            r_state <= ST_CLR_LINE;
            r_idx   <= 7'(CELLS - COLS);
          end else begin
            r_state <= ST_SCR_RD;
            r_idx   <= r_idx + 7'd1;
          end
        end
        ST_CLR_LINE, ST_CLR_ALL: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_idx;
          r_wr_data <= SPACE;
          if (r_idx == 7'(CELLS - 1)) begin
            r_state <= ST_IDLE;
            r_idx   <= 7'd0;
          end else begin
            r_idx <= r_idx + 7'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
